// File: rtl/dpwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : dpwm_deadtime_gen
// Purpose  : Digital PWM stage fed by the PID controller. Converts the signed
//            Q(FRAC) control word into a clamped duty count once per switching
//            period and drives complementary high/low-side gates with
//            programmable dead time. Also produces the f_pwm sample clock that
//            paces the PID loop, so controller update and PWM stay locked.
// Ports    : f_clk    in   system clock, rising edge
//            rst      in   asynchronous active-high reset
//            en       in   gate enable (low -> both gates off)
//            N_con    in   signed 19-bit control word (2^FRAC == duty 1.0)
//            f_pwm    out  PID sample clock, 50% duty, one cycle per period
//            pwm_hi   out  high-side gate
//            pwm_lo   out  low-side gate
//            duty_act out  duty count in use for the current period
//            sat      out  latched duty was clamped
// Revision : 1.0 - initial release
// ============================================================================
module dpwm_deadtime_gen #(
    parameter int PERIOD   = 500,
    parameter int CNT_W    = 10,
    parameter int DEADTIME = 4,
    parameter int D_MIN    = 0,
    parameter int D_MAX    = 480,
    parameter int FRAC     = 15
) (
    input  logic                f_clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [18:0]  N_con,
    output logic                f_pwm,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic [CNT_W-1:0]    duty_act,
    output logic                sat
);

    localparam int c_ncon_w = 19;
    localparam int c_prod_w = c_ncon_w + CNT_W;

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_half    = CNT_W'(PERIOD / 2);
    localparam logic [CNT_W-1:0] c_dmin    = CNT_W'(D_MIN);
    localparam logic [CNT_W-1:0] c_dmax    = CNT_W'(D_MAX);
    localparam logic [CNT_W-1:0] c_dt_load = CNT_W'(DEADTIME - 1);

    localparam logic signed [c_prod_w-1:0] c_period_s = c_prod_w'(PERIOD);
    localparam logic signed [c_prod_w-1:0] c_dmin_s   = c_prod_w'(D_MIN);
    localparam logic signed [c_prod_w-1:0] c_dmax_s   = c_prod_w'(D_MAX);

    // Gate FSM encoding
    localparam logic [2:0] c_st_off   = 3'd0;
    localparam logic [2:0] c_st_lo_on = 3'd1;
    localparam logic [2:0] c_st_dt_lh = 3'd2;
    localparam logic [2:0] c_st_hi_on = 3'd3;
    localparam logic [2:0] c_st_dt_hl = 3'd4;

    logic [CNT_W-1:0]           r_cnt;
    logic                       r_f_pwm;
    logic [CNT_W-1:0]           r_duty_pend;
    logic [CNT_W-1:0]           r_duty_act;
    logic                       r_sat;
    logic [2:0]                 r_state;
    logic [CNT_W-1:0]           r_dtc;
    logic                       r_pwm_hi;
    logic                       r_pwm_lo;

    logic                       w_wrap;
    logic                       w_sample;
    logic [CNT_W-1:0]           w_cnt_next;
    logic signed [c_prod_w-1:0] w_ncon_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_prod_w-1:0] w_dcalc;
    logic [CNT_W-1:0]           w_duty_next;
    logic                       w_sat_next;
    logic                       w_raw;
    logic [2:0]                 w_state_next;
    logic [CNT_W-1:0]           w_dtc_next;

    assign w_wrap     = (r_cnt == c_last);
    assign w_sample   = (r_cnt == c_half);
    assign w_cnt_next = w_wrap ? '0 : r_cnt + CNT_W'(1);

    // Duty = N_con * PERIOD / 2^FRAC, floor via arithmetic shift
    assign w_ncon_ext = c_prod_w'(N_con);
    assign w_prod     = w_ncon_ext * c_period_s;
    assign w_dcalc    = w_prod >>> FRAC;

    always_comb begin
        w_duty_next = w_dcalc[CNT_W-1:0];
        w_sat_next  = 1'b0;
        if (w_dcalc < c_dmin_s) begin
            w_duty_next = c_dmin;
            w_sat_next  = 1'b1;
        end else if (w_dcalc > c_dmax_s) begin
            w_duty_next = c_dmax;
            w_sat_next  = 1'b1;
        end
    end

    // Uncompensated PWM; the FSM turns its edges into dead-timed gates
    assign w_raw = (r_cnt < r_duty_act);

    always_comb begin
        w_state_next = r_state;
        w_dtc_next   = r_dtc;
        if (!en) begin
            w_state_next = c_st_off;
        end else begin
            case (r_state)
                c_st_off: begin
                    // Start on a period boundary; duty_pend is what raw
                    // will be compared against from cnt=0 onward.
                    if (w_wrap) begin
                        w_dtc_next   = c_dt_load;
                        w_state_next = (r_duty_pend != '0) ? c_st_dt_lh : c_st_dt_hl;
                    end
                end
                c_st_lo_on: begin
                    if (w_raw) begin
                        w_dtc_next   = c_dt_load;
                        w_state_next = c_st_dt_lh;
                    end
                end
                c_st_dt_lh: begin
                    if (!w_raw) begin
                        // Pulse shorter than the dead time is swallowed
                        w_state_next = c_st_lo_on;
                    end else if (r_dtc == '0) begin
                        w_state_next = c_st_hi_on;
                    end else begin
                        w_dtc_next = r_dtc - CNT_W'(1);
                    end
                end
                c_st_hi_on: begin
                    if (!w_raw) begin
                        w_dtc_next   = c_dt_load;
                        w_state_next = c_st_dt_hl;
                    end
                end
                c_st_dt_hl: begin
                    if (w_raw) begin
                        w_state_next = c_st_hi_on;
                    end else if (r_dtc == '0) begin
                        w_state_next = c_st_lo_on;
                    end else begin
                        w_dtc_next = r_dtc - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = c_st_off;
                end
            endcase
        end
    end

    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_f_pwm     <= 1'b0;
            r_duty_pend <= '0;
            r_duty_act  <= '0;
            r_sat       <= 1'b0;
            r_state     <= c_st_off;
            r_dtc       <= '0;
            r_pwm_hi    <= 1'b0;
            r_pwm_lo    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            // Decoded from the next count so the rising edge lands on cnt=0
            r_f_pwm <= (w_cnt_next < c_half);

            // Sample mid-period, after the PID has settled from f_pwm rise
            if (w_sample) begin
                r_duty_pend <= w_duty_next;
                r_sat       <= w_sat_next;
            end
            // Load at the wrap so duty never changes inside a period
            if (w_wrap) begin
                r_duty_act <= r_duty_pend;
            end

            r_state  <= w_state_next;
            r_dtc    <= w_dtc_next;
            r_pwm_hi <= (w_state_next == c_st_hi_on);
            r_pwm_lo <= (w_state_next == c_st_lo_on);
        end
    end

    assign f_pwm    = r_f_pwm;
    assign pwm_hi   = r_pwm_hi;
    assign pwm_lo   = r_pwm_lo;
    assign duty_act = r_duty_act;
    assign sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dpwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpwm_deadtime_gen
// Purpose  : Self-checking bench for dpwm_deadtime_gen. Stimulus pushes
//            per-period expectations into a queue; a monitor measures each
//            complete PWM period (f_pwm rise to f_pwm rise) and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpwm_deadtime_gen;

    localparam int c_period = 500;
    localparam int c_cnt_w  = 10;

    logic                  f_clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic signed [18:0]    N_con;
    logic                  f_pwm;
    logic                  pwm_hi;
    logic                  pwm_lo;
    logic [c_cnt_w-1:0]    duty_act;
    logic                  sat;

    always #5 f_clk = ~f_clk;

    dpwm_deadtime_gen #(
        .PERIOD   (c_period),
        .CNT_W    (c_cnt_w),
        .DEADTIME (4),
        .D_MIN    (0),
        .D_MAX    (480),
        .FRAC     (15)
    ) u_dut (
        .f_clk    (f_clk),
        .rst      (rst),
        .en       (en),
        .N_con    (N_con),
        .f_pwm    (f_pwm),
        .pwm_hi   (pwm_hi),
        .pwm_lo   (pwm_lo),
        .duty_act (duty_act),
        .sat      (sat)
    );

    // Expected observation for one full period; -1 means don't care
    typedef struct {
        int period;
        int duty;
        int sat;
        int hi;
        int lo;
        int blo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   period_idx = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input int d, input int s,
                        input int hi, input int lo, input int blo);
        exp_t e;
        e.period = p; e.duty = d; e.sat = s; e.hi = hi; e.lo = lo; e.blo = blo;
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int   rises = 0;
    logic prev_f = 1'b0;
    int   o_len, o_fhi, o_hi, o_lo, o_bh, o_blo, o_duty, o_sat;

    task automatic report(input int n);
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].period < n) begin
            checks++;
            errors++;
            $display("FAIL p%0d: expectation never matched", sb_q[0].period);
            void'(sb_q.pop_front());
        end
        while (sb_q.size() > 0 && sb_q[0].period == n) begin
            e = sb_q.pop_front();
            check($sformatf("p%0d period_len", n), o_len, c_period);
            check($sformatf("p%0d f_pwm_high", n), o_fhi, c_period / 2);
            check($sformatf("p%0d both_high", n), o_bh, 0);
            if (e.duty >= 0) check($sformatf("p%0d duty_act", n), o_duty, e.duty);
            if (e.sat >= 0)  check($sformatf("p%0d sat", n), o_sat, e.sat);
            if (e.hi >= 0)   check($sformatf("p%0d hi_cycles", n), o_hi, e.hi);
            if (e.lo >= 0)   check($sformatf("p%0d lo_cycles", n), o_lo, e.lo);
            if (e.blo >= 0)  check($sformatf("p%0d both_low", n), o_blo, e.blo);
        end
    endtask

    always @(negedge f_clk) begin
        if (rst) begin
            rises  = 0;
            prev_f = 1'b0;
        end else begin
            if (f_pwm && !prev_f) begin
                // First interval after reset is partial; skip it
                if (rises >= 2) report(period_idx);
                period_idx++;
                rises++;
                o_len = 0; o_fhi = 0; o_hi = 0; o_lo = 0; o_bh = 0; o_blo = 0;
                o_duty = int'(duty_act);
                o_sat  = int'(sat);
            end
            prev_f = f_pwm;
            if (rises >= 1) begin
                o_len++;
                if (f_pwm)             o_fhi++;
                if (pwm_hi)            o_hi++;
                if (pwm_lo)            o_lo++;
                if (pwm_hi && pwm_lo)  o_bh++;
                if (!pwm_hi && !pwm_lo) o_blo++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Move to the cnt=c cycle (c>=1) of period p, 2 time units after its edge
    task automatic goto(input int p, input int c);
        int guard;
        guard = 0;
        if (period_idx >= p) begin
            checks++;
            errors++;
            $display("FAIL sync: already at period %0d, wanted %0d", period_idx, p);
        end
        while (period_idx < p && guard < 4000) begin
            @(posedge f_clk);
            guard++;
        end
        if (period_idx < p) begin
            checks++;
            errors++;
            $display("FAIL timeout: period %0d, wanted %0d", period_idx, p);
        end
        repeat (c - 1) @(posedge f_clk);
        #2;
    endtask

    initial begin
        int guard;
        rst   = 1'b1;
        en    = 1'b1;
        N_con = 19'sd16384;
        repeat (3) @(posedge f_clk);
        #2;
        check("reset f_pwm", int'(f_pwm), 0);
        check("reset pwm_hi", int'(pwm_hi), 0);
        check("reset pwm_lo", int'(pwm_lo), 0);
        check("reset duty_act", int'(duty_act), 0);
        check("reset sat", int'(sat), 0);
        rst = 1'b0;

        // Mid-scale 0.5 -> 250
        push(2, 250, 0, -1, -1, -1);
        push(3, 250, 0, 246, 246, 8);
        push(4, 250, 0, 246, 246, 8);

        // Asynchronous reset while high side is on
        goto(5, 100);
        check("pre-reset pwm_hi", int'(pwm_hi), 1);
        #1 rst = 1'b1;
        #1;
        check("async rst pwm_hi", int'(pwm_hi), 0);
        check("async rst pwm_lo", int'(pwm_lo), 0);
        check("async rst f_pwm", int'(f_pwm), 0);
        repeat (3) @(posedge f_clk);
        #2 rst = 1'b0;
        push(7, 250, 0, -1, -1, -1);
        push(8, 250, 0, 246, 246, 8);

        // Negative input clamps to 0
        goto(9, 10);
        N_con = -19'sd1000;
        push(10, 0, 1, 0, 500, 0);
        push(11, 0, 1, 0, 500, 0);

        // Over-range: dcalc 610 clamps to 480
        goto(12, 10);
        N_con = 19'sd40000;
        push(13, 480, 1, 476, 16, 8);
        push(14, 480, 1, 476, 16, 8);

        // Step after the sample point: one extra period of old duty
        goto(15, 10);
        N_con = 19'sd8192;
        push(16, 125, 0, 121, 371, 8);
        goto(16, 260);
        N_con = 19'sd24576;
        push(17, 125, 0, 121, 371, 8);
        push(18, 375, 0, 371, 121, 8);

        // Step before the sample point: applies from the next cnt=0
        goto(19, 100);
        N_con = 19'sd16384;
        push(19, 375, 0, 371, 121, 8);
        push(20, 250, 0, 246, 246, 8);

        // Duty 1 is shorter than the dead time: pulse swallowed
        goto(21, 10);
        N_con = 19'sd98;
        push(22, 1, 0, 0, 499, 1);
        push(23, 1, 0, 0, 499, 1);

        // Enable drop mid high-side pulse
        goto(24, 10);
        N_con = 19'sd16384;
        push(25, 250, 0, 246, 246, 8);
        goto(26, 100);
        check("pre-disable pwm_hi", int'(pwm_hi), 1);
        en = 1'b0;
        @(posedge f_clk);
        @(negedge f_clk);
        check("disable pwm_hi", int'(pwm_hi), 0);
        check("disable pwm_lo", int'(pwm_lo), 0);
        push(27, 250, 0, 0, 0, 500);

        guard = 0;
        while (sb_q.size() > 0 && guard < 3000) begin
            @(posedge f_clk);
            guard++;
        end
        while (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: p%0d expectation not reached", sb_q[0].period);
            void'(sb_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpwm_deadtime_gen.md
Name: dpwm_deadtime_gen

Overview:
- Digital PWM stage directly downstream of the PID controller.
- Consumes the signed 19-bit control word N_con and turns it into a duty count per switching period.
- Drives complementary high-side/low-side gate signals with programmable dead time.
- Generates the f_pwm sample clock that paces the PID loop, so controller update and PWM period stay phase-locked.

Parameters:
- PERIOD, 500: switching period in f_clk cycles; must be even and at least 4.
- CNT_W, 10: counter and duty width; requires 2^CNT_W > PERIOD.
- DEADTIME, 4: both-off cycles inserted before each gate turn-on; must be at least 1.
- D_MIN, 0: minimum duty count after clamping.
- D_MAX, 480: maximum duty count after clamping; requires D_MAX ≤ PERIOD.
- FRAC, 15: fractional bits of N_con. N_con = 2^FRAC represents duty 1.0.

Ports:
- f_clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  gate enable. When low, both gates are off.
- N_con  in  19  signed control word from the PID stage.
- f_pwm  out  1  sample clock for the PID stage, 50% duty, one cycle per PWM period.
- pwm_hi  out  1  high-side gate.
- pwm_lo  out  1  low-side gate.
- duty_act  out  CNT_W  duty count in use for the current period.
- sat  out  1  set when the latched duty was clamped (N_con negative or above range).

Behaviour:
- Reset values: cnt=0, f_pwm=0, duty_pend=0, duty_act=0, sat=0, pwm_hi=0, pwm_lo=0, FSM=OFF.
- Reset is asynchronous: outputs go low immediately, including mid-period.
- Counter: cnt runs 0..PERIOD-1 and wraps to 0. It runs regardless of en.
- f_pwm: registered; high while cnt < PERIOD/2, otherwise low. Its rising edge coincides with cnt=0.
- Duty computation: prod = N_con * PERIOD, 29-bit signed. dcalc = prod >>> FRAC (arithmetic shift).
- Clamping: if dcalc < D_MIN, use D_MIN with sat_next=1. If dcalc > D_MAX, use D_MAX with sat_next=1. Otherwise use dcalc with sat_next=0.
- Sampling: on the cycle cnt == PERIOD/2, the clamped value is latched into duty_pend along with sat_next. This is mid-period, after PID outputs have settled from the f_pwm rising edge.
- Loading: on the cycle cnt == PERIOD-1, duty_pend is copied to duty_act. The new duty takes effect from cnt=0.
- Latency: N_con is held for one full period before it drives the gates. Duty never changes mid-period, so there are no glitch pulses.
- sat updates together with duty_pend.
- Raw PWM: raw = (cnt < duty_act), combinational.
- Gate FSM: states OFF, LO_ON, DT_LH, HI_ON, DT_HL. A dead-time counter dtc loads DEADTIME-1 on entry to DT_LH or DT_HL.
  - OFF: both gates low. If en=1 and cnt==PERIOD-1, go to DT_LH if the next-period raw is high, else DT_HL.
  - LO_ON: pwm_lo=1. If raw goes high, go to DT_LH.
  - DT_LH: both gates low. When dtc reaches 0 and raw is still high, go to HI_ON. If raw goes low first, go to LO_ON (pulse swallowed).
  - HI_ON: pwm_hi=1. If raw goes low, go to DT_HL.
  - DT_HL: symmetric to DT_LH. When dtc reaches 0 and raw is still low, go to LO_ON. If raw goes high first, go to HI_ON.
  - From any state: en=0 forces OFF on the next edge.
- Gate outputs are registered decodes of the FSM state. pwm_hi and pwm_lo are never high together.
- duty_act = PERIOD gives raw permanently high, so HI_ON is held across the wrap with no dead time.
- duty_act = 0 gives LO_ON held continuously.
- Steady-state pulse widths for D_MIN+DEADTIME ≤ duty ≤ PERIOD-DEADTIME:
  - pwm_hi is high for duty − DEADTIME cycles per period.
  - pwm_lo is high for PERIOD − duty − DEADTIME cycles per period.
- Simultaneous events: cnt==PERIOD/2 and cnt==PERIOD-1 cannot coincide because PERIOD ≥ 4. A load at wrap together with a raw edge uses the new duty_act from cnt=0.

Test Plan:
- Reset and en stimulus: assert rst mid-period while pwm_hi=1. Require pwm_hi=pwm_lo=f_pwm=0 immediately, before any clock. After release, require f_pwm high for 250 cycles and low for 250, repeating.
- Mid-scale duty: en=1, N_con=16384 (0.5). From the second full period, require duty_act=250, sat=0, pwm_hi high for 246 cycles, pwm_lo high for 246, both low for 4 cycles at each edge.
- Negative input: N_con=-1000. Require duty_act=0, sat=1, pwm_lo=1 continuously, pwm_hi=0.
- Over-range input: N_con=40000 (dcalc=610). Require duty_act=480, sat=1, pwm_hi high for 476 cycles, pwm_lo high for 16.
- Update timing: step N_con 8192→24576 at cnt=260 (after sampling). Require duty_act to stay 125 for the next period, then become 375. A step at cnt=100 must instead apply from the very next cnt=0.
- Short pulse and enable: N_con=98 (duty 1 < DEADTIME). Require the pulse to be swallowed: pwm_hi never high, and no cycle with both gates high. Drop en mid-HI_ON and require both gates low on the next edge.
